// File: rtl/read_miss_issuer_pkg.sv
// Types shared by the read-miss issue path.
//   state_t : issue FSM states (idle / waiting for AR handshake / FIFO push).
package read_miss_issuer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_PUSH  = 2'd2
  } state_t;

endpackage

// File: rtl/TYPEDEF.svh
// Shared width macros for the cache/CXL read path.
//   AXI_ADDR_WIDTH : width of line addresses carried on the AXI/CXL read channel.
`ifndef TYPEDEF_SVH
`define TYPEDEF_SVH

`define AXI_ADDR_WIDTH 32

`endif

// File: rtl/read_miss_issuer_credit_counter.sv
// miss_credit_counter: tracks in-flight CXL reads.
//   clk, rst : clock, synchronous active-high reset
//   inc      : one in-flight read added this cycle
//   dec      : one response consumed this cycle
//   count    : current in-flight count
//   at_max   : count has reached MAX_OUTSTANDING
//   err      : sticky, set by dec arriving while count is zero
module miss_credit_counter #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CW              = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          at_max,
  output logic          err
);

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          err_reg;
  logic          dec_ok;

  // A response with nothing outstanding is dropped rather than wrapping the count.
  assign dec_ok = dec && (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (inc && !dec_ok)
      count_next = count_reg + CW'(1);
    else if (dec_ok && !inc)
      count_next = count_reg - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (dec && (count_reg == '0))
        err_reg <= 1'b1;
    end
  end

  assign count  = count_reg;
  assign at_max = (count_reg == MAX_CNT);
  assign err    = err_reg;

endmodule

// File: rtl/read_miss_issuer.sv
// read_miss_issuer: turns tag-check misses into CXL read requests, one at a
// time, and records each issued address in R_MISS_FIFO in issue order.
//   miss_valid_i/miss_addr_i/miss_ready_o : miss request handshake
//   ar_valid_o/ar_ready_i/ar_addr_o       : read request to CXL controller
//   write_en_o/full_i/wdata_o             : push side of R_MISS_FIFO
//   rsp_done_i                            : one pulse per consumed read response
//   outstanding_o                         : reads currently in flight
//   err_o                                 : sticky response-underflow flag
`include "TYPEDEF.svh"

module read_miss_issuer
  import read_miss_issuer_pkg::*;
#(
  parameter int ADDR_WIDTH      = `AXI_ADDR_WIDTH,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               miss_valid_i,
  input  logic [ADDR_WIDTH-1:0]              miss_addr_i,
  output logic                               miss_ready_o,
  output logic                               ar_valid_o,
  input  logic                               ar_ready_i,
  output logic [ADDR_WIDTH-1:0]              ar_addr_o,
  output logic                               write_en_o,
  input  logic                               full_i,
  output logic [ADDR_WIDTH-1:0]              wdata_o,
  input  logic                               rsp_done_i,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o,
  output logic                               err_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  ar_valid_reg, ar_valid_next;
  logic                  write_en_reg, write_en_next;
  logic [ADDR_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  at_max;
  logic                  ar_fire;

  // FIFO space is checked only here; being the only writer, the slot is
  // still free when the push happens two or more cycles later.
  assign miss_ready_o = !rst && (state_reg == S_IDLE) && !at_max && !full_i;
  assign ar_fire      = ar_valid_reg && ar_ready_i;

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    ar_valid_next = ar_valid_reg;
    write_en_next = 1'b0;
    wdata_next    = wdata_reg;
    case (state_reg)
      S_IDLE: begin
        if (miss_valid_i && miss_ready_o) begin
          addr_next     = miss_addr_i;
          ar_valid_next = 1'b1;
          state_next    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ar_fire) begin
          ar_valid_next = 1'b0;
          write_en_next = 1'b1;
          wdata_next    = addr_reg;
          state_next    = S_PUSH;
        end
      end
      S_PUSH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next    = S_IDLE;
        ar_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      ar_valid_reg <= 1'b0;
      write_en_reg <= 1'b0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      ar_valid_reg <= ar_valid_next;
      write_en_reg <= write_en_next;
      wdata_reg    <= wdata_next;
    end
  end

  // The count steps on the handshake edge, so it reads one more in the
  // same cycle the FIFO push strobe is high.
  miss_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CW             (CW)
  ) u_credit (
    .clk   (clk),
    .rst   (rst),
    .inc   (state_reg == S_ISSUE && ar_fire),
    .dec   (rsp_done_i),
    .count (outstanding_o),
    .at_max(at_max),
    .err   (err_o)
  );

  assign ar_valid_o = ar_valid_reg;
  assign ar_addr_o  = addr_reg;
  assign write_en_o = write_en_reg;
  assign wdata_o    = wdata_reg;

endmodule
